switch_reader: RTL and testbench

//  CPU-side read path for board inputs; counterpart of the LED/7-seg write path.

---
 rtl/switch_reader_pkg.sv | 25 ++
 rtl/debounce_filter.sv | 52 +++++
 rtl/switch_reader.sv | 125 ++++++++++++
 tb/tb_switch_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_reader_pkg.sv
// Shared IO-window map and types for the board-input read path.
package switch_reader_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SW_W   = 16;

   localparam logic [DATA_W-1:0] ADDR_DATA   = 32'hffff_ffc8;
   localparam logic [DATA_W-1:0] ADDR_STATUS = 32'hffff_ffcc;
   localparam logic [DATA_W-1:0] ADDR_RAW    = 32'hffff_ffd0;

   localparam int unsigned VALID_BIT   = 0;
   localparam int unsigned OVERRUN_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1
   } press_state_e;

   // Field order places valid at VALID_BIT and overrun at OVERRUN_BIT.
   typedef struct packed {
      logic overrun;
      logic valid;
   } status_t;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus group debounce: the whole vector must hold still
// for DEBOUNCE_CYCLES clocks before it is published on stable_o.
module debounce_filter #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any change restarts the interval; publish once the count first hits max.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_d == CNT_MAX) begin
            stable_d = sync2_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/switch_reader.sv
// CPU read responder for debounced slide switches and confirm button; each
// confirmed press latches the switch word and raises a sticky valid flag.
module switch_reader
   import switch_reader_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SW_W-1:0]   switchInput,
   input  logic              confirmation,
   input  logic              readEn,
   input  logic [DATA_W-1:0] address,
   output logic [DATA_W-1:0] readData,
   output logic              ioValid
);

   logic [SW_W-1:0] stable_sw;
   logic            btn_stable;

   press_state_e    state_q, state_d;
   logic            capture_c;
   logic            rd_data_c, rd_status_c;

   logic [SW_W-1:0] data_q, data_d;
   status_t         status_q, status_d;

   debounce_filter #(
      .WIDTH           (SW_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_sw_filter (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (switchInput),
      .stable_o (stable_sw)
   );

   debounce_filter #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn_filter (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (confirmation),
      .stable_o (btn_stable)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Press detector: only the IDLE->PRESSED edge captures.
   always_comb begin
      state_d   = state_q;
      capture_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_stable) begin
               state_d   = ST_PRESSED;
               capture_c = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!btn_stable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rd_data_c   = readEn && (address == ADDR_DATA);
   assign rd_status_c = readEn && (address == ADDR_STATUS);

   // Clearing reads are applied first so a same-cycle capture wins.
   always_comb begin
      data_d   = data_q;
      status_d = status_q;
      if (rd_data_c) begin
         status_d.valid = 1'b0;
      end
      if (rd_status_c) begin
         status_d.overrun = 1'b0;
      end
      if (capture_c) begin
         data_d         = stable_sw;
         status_d.valid = 1'b1;
         if (status_q.valid) begin
            status_d.overrun = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q   <= '0;
         status_q <= '0;
      end else begin
         data_q   <= data_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      readData = '0;
      if (readEn) begin
         case (address)
            ADDR_DATA:   readData = DATA_W'(data_q);
            ADDR_STATUS: readData = DATA_W'(status_q);
            ADDR_RAW:    readData = DATA_W'(stable_sw);
            default:     readData = '0;
         endcase
      end
   end

   assign ioValid = status_q.valid;

endmodule

// File: tb/tb_switch_reader.sv
// Bench for switch_reader with a short debounce interval: directed vector table,
// hand-written corner sequences and random traffic against a history-based model.
module tb_switch_reader;
   import switch_reader_pkg::*;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] switchInput = '0;
   logic        confirmation = 1'b0;
   logic        readEn = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] readData;
   logic        ioValid;

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   switch_reader #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .switchInput  (switchInput),
      .confirmation (confirmation),
      .readEn       (readEn),
      .address      (address),
      .readData     (readData),
      .ioValid      (ioValid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a value is accepted once D+1 consecutive synchronised
   // samples (taken two clocks after the raw input) agree since reset.
   logic [15:0] sw_hist[$];
   logic [15:0] btn_hist[$];
   logic [15:0] m_sw, m_data;
   logic        m_btn, m_pressed, m_valid, m_ovr;

   function automatic logic [15:0] deb_next(input logic [15:0] h[$], input logic [15:0] cur);
      int n = h.size();
      if (n < D + 2) return cur;
      for (int i = n - 2 - D; i < n - 2; i++)
         if (h[i] != h[n-2]) return cur;
      return h[n-2];
   endfunction

   function automatic logic [31:0] exp_rd();
      if (!readEn) return 32'h0;
      if (address == ADDR_DATA)   return {16'h0, m_data};
      if (address == ADDR_STATUS) return {30'h0, m_ovr, m_valid};
      if (address == ADDR_RAW)    return {16'h0, m_sw};
      return 32'h0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_hist   = '{16'h0, 16'h0, 16'h0};
         btn_hist  = '{16'h0, 16'h0, 16'h0};
         m_sw      = '0;
         m_data    = '0;
         m_btn     = 1'b0;
         m_pressed = 1'b0;
         m_valid   = 1'b0;
         m_ovr     = 1'b0;
      end else begin : model_step
         logic        cap, rdd, rds;
         logic [15:0] t;
         cap = m_btn && !m_pressed;
         rdd = readEn && (address == ADDR_DATA);
         rds = readEn && (address == ADDR_STATUS);
         m_ovr   = (cap && m_valid) || (m_ovr && !rds);
         m_valid = cap || (m_valid && !rdd);
         if (cap) m_data = m_sw;
         m_pressed = m_btn;
         m_sw = deb_next(sw_hist, m_sw);
         t = deb_next(btn_hist, {15'h0, m_btn});
         m_btn = t[0];
         sw_hist.push_back(switchInput);
         btn_hist.push_back({15'h0, confirmation});
         if (sw_hist.size() > D + 3) void'(sw_hist.pop_front());
         if (btn_hist.size() > D + 3) void'(btn_hist.pop_front());
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("model_readData", readData, exp_rd());
         chk("model_ioValid", {31'h0, ioValid}, {31'h0, m_valid});
      end
   end

   typedef struct {
      string       name;
      logic [15:0] sw;
      logic        btn;
      logic        rd;
      logic [31:0] addr;
      int          cyc;
      logic [31:0] exp_rd;
      logic        exp_v;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic [15:0] sw, input logic btn,
                               input logic rd, input logic [31:0] a, input int cyc,
                               input logic [31:0] er, input logic ev);
      vec_t v;
      v.name = n; v.sw = sw; v.btn = btn; v.rd = rd; v.addr = a;
      v.cyc = cyc; v.exp_rd = er; v.exp_v = ev;
      return v;
   endfunction

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      switchInput = v.sw; confirmation = v.btn; readEn = v.rd; address = v.addr;
      repeat (v.cyc - 1) @(posedge clk);
      @(negedge clk);
      chk({v.name, "_rd"}, readData, v.exp_rd);
      chk({v.name, "_v"}, {31'h0, ioValid}, {31'h0, v.exp_v});
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string n);
      readEn = 1'b1; address = a;
      @(negedge clk);
      chk(n, readData, e);
      @(posedge clk);
      #1;
      readEn = 1'b0; address = '0;
   endtask

   initial begin
      // Reset with inputs toggling
      @(posedge clk);
      mon_en = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         switchInput = 16'($urandom); confirmation = ~confirmation; readEn = 1'b1;
         address = (i % 3 == 0) ? ADDR_STATUS : (i % 3 == 1) ? ADDR_RAW : ADDR_DATA;
         @(negedge clk);
         chk("reset_readData", readData, 32'h0);
         chk("reset_ioValid", {31'h0, ioValid}, 32'h0);
         @(posedge clk);
         #1;
      end
      switchInput = '0; confirmation = 1'b0; readEn = 1'b0; address = '0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) rd_chk(ADDR_STATUS, 32'h0, "post_reset_status");
      hold(10);

      tbl.push_back(mk("settle_sw",   16'hA5C3, 0, 0, 32'h0,        8,  32'h0,         0));
      tbl.push_back(mk("press1",      16'hA5C3, 1, 0, 32'h0,        10, 32'h0,         1));
      tbl.push_back(mk("status_v",    16'hA5C3, 0, 1, ADDR_STATUS,  1,  32'h1,         1));
      tbl.push_back(mk("raw",         16'hA5C3, 0, 1, ADDR_RAW,     1,  32'h0000_A5C3, 1));
      tbl.push_back(mk("data1",       16'hA5C3, 0, 1, ADDR_DATA,    1,  32'h0000_A5C3, 1));
      tbl.push_back(mk("status_clr",  16'hA5C3, 0, 1, ADDR_STATUS,  1,  32'h0,         0));
      tbl.push_back(mk("unmapped",    16'hA5C3, 0, 1, 32'hffff_ffc4, 1, 32'h0,         0));
      tbl.push_back(mk("rden_low",    16'hA5C3, 0, 0, ADDR_DATA,    8,  32'h0,         0));
      tbl.push_back(mk("settle_1234", 16'h1234, 0, 0, 32'h0,        8,  32'h0,         0));
      tbl.push_back(mk("press_1234",  16'h1234, 1, 0, 32'h0,        10, 32'h0,         1));
      tbl.push_back(mk("settle_5678", 16'h5678, 0, 0, 32'h0,        8,  32'h0,         1));
      tbl.push_back(mk("press_5678",  16'h5678, 1, 0, 32'h0,        10, 32'h0,         1));
      tbl.push_back(mk("ovr_status",  16'h5678, 0, 1, ADDR_STATUS,  1,  32'h3,         1));
      tbl.push_back(mk("ovr_cleared", 16'h5678, 0, 1, ADDR_STATUS,  1,  32'h1,         1));
      tbl.push_back(mk("ovr_data",    16'h5678, 0, 1, ADDR_DATA,    1,  32'h0000_5678, 1));
      tbl.push_back(mk("ovr_final",   16'h5678, 0, 1, ADDR_STATUS,  1,  32'h0,         0));
      tbl.push_back(mk("idle",        16'h5678, 0, 0, 32'h0,        10, 32'h0,         0));
      foreach (tbl[i]) apply(tbl[i]);

      // Bouncing button then held: one capture only
      for (int i = 0; i < 10; i++) begin
         confirmation = ~confirmation;
         hold(2);
      end
      confirmation = 1'b1;
      hold(10);
      rd_chk(ADDR_STATUS, 32'h1, "bounce_one_capture");
      rd_chk(ADDR_DATA, 32'h0000_5678, "bounce_data");
      confirmation = 1'b0;

      // Three-clock switch glitch is filtered out
      switchInput = 16'hFFFF;
      hold(3);
      switchInput = 16'h5678;
      hold(12);
      rd_chk(ADDR_RAW, 32'h0000_5678, "glitch_raw");

      // Capture and DATA read on the same edge
      switchInput = 16'h1111; hold(8);
      confirmation = 1'b1; hold(10);
      confirmation = 1'b0; hold(10);
      switchInput = 16'h2222; hold(8);
      confirmation = 1'b1;
      hold(7);
      readEn = 1'b1; address = ADDR_DATA;
      @(negedge clk);
      chk("coll_old_word", readData, 32'h0000_1111);
      @(posedge clk);
      #1;
      readEn = 1'b0; address = '0;
      @(negedge clk);
      chk("coll_valid_kept", {31'h0, ioValid}, 32'h1);
      @(posedge clk);
      #1;
      rd_chk(ADDR_STATUS, 32'h3, "coll_status");
      rd_chk(ADDR_DATA, 32'h0000_2222, "coll_new_word");
      confirmation = 1'b0; hold(10);

      // Reset while the button is held
      switchInput = 16'h3C3C; hold(8);
      confirmation = 1'b1; hold(10);
      rst = 1'b0;
      readEn = 1'b1; address = ADDR_STATUS;
      @(negedge clk);
      chk("rst_mid_status", readData, 32'h0);
      chk("rst_mid_valid", {31'h0, ioValid}, 32'h0);
      hold(3);
      readEn = 1'b0; address = '0;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_no_early_capture", {31'h0, ioValid}, 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
      chk("rst_late_capture", {31'h0, ioValid}, 32'h1);
      @(posedge clk);
      #1;
      rd_chk(ADDR_DATA, 32'h0000_3C3C, "rst_capture_data");
      confirmation = 1'b0; hold(10);

      // Random traffic checked by the model
      for (int seg = 0; seg < 250; seg++) begin
         int len;
         case ($urandom_range(0, 3))
            0: switchInput = 16'h0F0F;
            1: switchInput = 16'hBEEF;
            2: switchInput = 16'h0001;
            default: switchInput = 16'($urandom);
         endcase
         confirmation = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 10));
         for (int c = 0; c < len; c++) begin
            readEn = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
               0: address = ADDR_DATA;
               1: address = ADDR_STATUS;
               2: address = ADDR_RAW;
               default: address = $urandom;
            endcase
            if ($urandom_range(0, 300) == 0) rst = 1'b0;
            else rst = 1'b1;
            hold(1);
         end
      end
      rst = 1'b1; readEn = 1'b0;
      hold(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
